// File: rtl/memory_stage.sv
// MEM pipeline stage: req/ack data-memory access, front-of-pipe stall and the M->W register.
// Optional access timeout with sticky error flag is enabled by defining MEM_TIMEOUT_EN.
module memory_stage #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RegWriteM,
    input  logic [1:0]         ResultSrcM,
    input  logic               MemWriteM,
    input  logic               ATypeM,
    input  logic [D_WIDTH-1:0] ALUResultM,
    input  logic [D_WIDTH-1:0] WriteDataM,
    input  logic [A_WIDTH-1:0] RdM,
    input  logic [D_WIDTH-1:0] PCPlus4M,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic               mem_we,
    output logic [D_WIDTH-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    output logic [3:0]         mem_be,
    output logic               StallM,
    output logic               mem_err,
    output logic               RegWriteW,
    output logic [1:0]         ResultSrcW,
    output logic [D_WIDTH-1:0] ALUResultW,
    output logic [D_WIDTH-1:0] ReadDataW,
    output logic [A_WIDTH-1:0] RdW,
    output logic [D_WIDTH-1:0] PCPlus4W
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic               access_s;
    logic               timeout_s;
    logic               mem_req_s;
    logic               stall_s;
    logic [1:0]         byte_sel_s;
    logic [7:0]         rbyte_s;
    logic [D_WIDTH-1:0] read_data_s;

    logic               reg_write_q, reg_write_d;
    logic [1:0]         result_src_q, result_src_d;
    logic [D_WIDTH-1:0] alu_result_q, alu_result_d;
    logic [D_WIDTH-1:0] read_data_q, read_data_d;
    logic [A_WIDTH-1:0] rd_q, rd_d;
    logic [D_WIDTH-1:0] pc_plus4_q, pc_plus4_d;

    // A store with a load encoding is still just a store.
    assign access_s   = MemWriteM | (ResultSrcM == 2'b01);
    assign byte_sel_s = ALUResultM[1:0];

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;

    // Wait-cycle counter and sticky error next-state.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q | timeout_s;
        if (state_q == S_IDLE) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != {CNT_W{1'b1}}) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Timeout counter and error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign timeout_s = (state_q == S_WAIT) & ~mem_ack &
                       ((32'(wait_cnt_q) + 32'd1) >= 32'(TIMEOUT_CYCLES));
    assign mem_err   = mem_err_q;
`else
    assign timeout_s = 1'b0;
    assign mem_err   = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (access_s && !mem_ack) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (mem_ack || timeout_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: request and stall.
    always_comb begin
        mem_req_s = 1'b0;
        stall_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                mem_req_s = access_s;
                stall_s   = access_s & ~mem_ack;
            end
            S_WAIT: begin
                mem_req_s = 1'b1;
                stall_s   = ~mem_ack & ~timeout_s;
            end
            default: begin
                mem_req_s = 1'b0;
                stall_s   = 1'b0;
            end
        endcase
    end

    // Reset must drop the request at once, even if upstream still presents an access.
    assign mem_req  = mem_req_s & ~rst;
    assign mem_we   = MemWriteM;
    assign mem_addr = {ALUResultM[D_WIDTH-1:2], 2'b00};
    assign StallM   = stall_s;

    // Byte lanes and load data formatting.
    always_comb begin
        mem_be    = 4'hF;
        mem_wdata = WriteDataM[31:0];
        rbyte_s   = mem_rdata[7:0];
        case (byte_sel_s)
            2'd0:    rbyte_s = mem_rdata[7:0];
            2'd1:    rbyte_s = mem_rdata[15:8];
            2'd2:    rbyte_s = mem_rdata[23:16];
            2'd3:    rbyte_s = mem_rdata[31:24];
            default: rbyte_s = mem_rdata[7:0];
        endcase
        if (ATypeM) begin
            mem_be    = 4'b0001 << byte_sel_s;
            mem_wdata = {4{WriteDataM[7:0]}};
        end else begin
            mem_be    = 4'hF;
            mem_wdata = WriteDataM[31:0];
        end
        if (timeout_s) begin
            read_data_s = D_WIDTH'(32'hDEADBEEF);
        end else if (ATypeM) begin
            read_data_s = D_WIDTH'({24'h000000, rbyte_s});
        end else begin
            read_data_s = D_WIDTH'(mem_rdata);
        end
    end

    // M->W next-state: capture on progress, bubble while stalled.
    always_comb begin
        reg_write_d  = reg_write_q;
        result_src_d = result_src_q;
        alu_result_d = alu_result_q;
        read_data_d  = read_data_q;
        rd_d         = rd_q;
        pc_plus4_d   = pc_plus4_q;
        if (stall_s) begin
            reg_write_d = 1'b0;
        end else begin
            reg_write_d  = RegWriteM;
            result_src_d = ResultSrcM;
            alu_result_d = ALUResultM;
            read_data_d  = read_data_s;
            rd_d         = RdM;
            pc_plus4_d   = PCPlus4M;
        end
    end

    // M->W pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            alu_result_q <= '0;
            read_data_q  <= '0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
        end
    end

    assign RegWriteW  = reg_write_q;
    assign ResultSrcW = result_src_q;
    assign ALUResultW = alu_result_q;
    assign ReadDataW  = read_data_q;
    assign RdW        = rd_q;
    assign PCPlus4W   = pc_plus4_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected W entries are queued at issue and checked at retirement.
module tb_memory_stage;

    logic        clk;
    logic        rst;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic        ATypeM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        StallM;
    logic        mem_err;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [31:0] PCPlus4W;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        chk_rdata;
        logic [4:0]  rd;
        logic [31:0] pc4;
    } w_exp_t;

    w_exp_t exp_q[$];
    int     n_checks = 0;
    int     n_fails  = 0;
    logic   expect_w = 1'b0;

    memory_stage #(
        .D_WIDTH(32),
        .A_WIDTH(5)
`ifdef MEM_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM), .ATypeM(ATypeM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .StallM(StallM), .mem_err(mem_err),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_nop();
        RegWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        MemWriteM  = 1'b0;
        ATypeM     = 1'b0;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        RdM        = 5'd0;
        PCPlus4M   = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    // Retirement monitor: pops one entry on each completion edge, otherwise expects a bubble.
    always @(posedge clk) begin
        #1;
        if (expect_w) begin
            if (exp_q.size() == 0) begin
                check_val("w_queue_empty", 32'd1, 32'd0);
            end else begin
                w_exp_t e;
                e = exp_q.pop_front();
                check_val("RegWriteW", {31'b0, RegWriteW}, {31'b0, e.rw});
                check_val("ResultSrcW", {30'b0, ResultSrcW}, {30'b0, e.rs});
                check_val("ALUResultW", ALUResultW, e.alu);
                check_val("RdW", {27'b0, RdW}, {27'b0, e.rd});
                check_val("PCPlus4W", PCPlus4W, e.pc4);
                if (e.chk_rdata) check_val("ReadDataW", ReadDataW, e.rdata);
            end
        end else begin
            check_val("bubble_RegWriteW", {31'b0, RegWriteW}, 32'd0);
        end
    end

    // Issue one instruction; memory acks after `waits` stalled cycles. Called at posedge+2.
    task automatic do_op(input logic rw, input logic [1:0] rs, input logic mw, input logic at,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] pc4, input int waits, input logic [31:0] rdata,
                         input logic stray_ack);
        logic        acc;
        logic        is_ld;
        logic [3:0]  be;
        logic [31:0] wdat;
        logic [31:0] rexp;
        w_exp_t      e;
        int          nw;
        acc   = mw | (rs == 2'b01);
        is_ld = (rs == 2'b01) & ~mw;
        nw    = acc ? waits : 0;
        be    = 4'hF;
        wdat  = wd;
        rexp  = rdata;
        if (at) begin
            case (alu[1:0])
                2'd0: begin be = 4'b0001; rexp = {24'h0, rdata[7:0]};   end
                2'd1: begin be = 4'b0010; rexp = {24'h0, rdata[15:8]};  end
                2'd2: begin be = 4'b0100; rexp = {24'h0, rdata[23:16]}; end
                default: begin be = 4'b1000; rexp = {24'h0, rdata[31:24]}; end
            endcase
            wdat = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        end
        e = '{rw: rw, rs: rs, alu: alu, rdata: rexp, chk_rdata: is_ld, rd: rd, pc4: pc4};
        exp_q.push_back(e);
        for (int c = 0; c <= nw; c++) begin
            RegWriteM  = rw;
            ResultSrcM = rs;
            MemWriteM  = mw;
            ATypeM     = at;
            ALUResultM = alu;
            WriteDataM = wd;
            RdM        = rd;
            PCPlus4M   = pc4;
            mem_rdata  = rdata;
            mem_ack    = acc ? (c == nw) : stray_ack;
            expect_w   = (c == nw);
            @(negedge clk);
            check_val("mem_req", {31'b0, mem_req}, {31'b0, acc});
            check_val("StallM", {31'b0, StallM}, {31'b0, (acc && (c < nw))});
            if (acc) begin
                check_val("mem_we", {31'b0, mem_we}, {31'b0, mw});
                check_val("mem_addr", mem_addr, {alu[31:2], 2'b00});
                check_val("mem_be", {28'b0, mem_be}, {28'b0, be});
                if (mw) check_val("mem_wdata", mem_wdata, wdat);
            end
            @(posedge clk);
            #2;
        end
        expect_w = 1'b0;
        drive_nop();
    endtask

    task automatic check_w_zero(input string tag);
        check_val({tag, "_RegWriteW"}, {31'b0, RegWriteW}, 32'd0);
        check_val({tag, "_ResultSrcW"}, {30'b0, ResultSrcW}, 32'd0);
        check_val({tag, "_ALUResultW"}, ALUResultW, 32'd0);
        check_val({tag, "_ReadDataW"}, ReadDataW, 32'd0);
        check_val({tag, "_RdW"}, {27'b0, RdW}, 32'd0);
        check_val({tag, "_PCPlus4W"}, PCPlus4W, 32'd0);
        check_val({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
        check_val({tag, "_mem_err"}, {31'b0, mem_err}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive_nop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_w_zero("reset");
        check_val("reset_StallM", {31'b0, StallM}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Zero-wait LW, slow SB, LBU with stall, non-memory op with a stray ack.
        do_op(1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 5'd5, 32'h0000_1004, 0, 32'h1234_5678, 1'b0);
        do_op(1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_0203, 32'h0000_00AB, 5'd0, 32'h0000_1008, 3, 32'h0, 1'b0);
        do_op(1'b1, 2'b01, 1'b0, 1'b1, 32'h0000_00FE, 32'h0, 5'd9, 32'h0000_100C, 2, 32'hAABB_CCDD, 1'b0);
        do_op(1'b1, 2'b00, 1'b0, 1'b0, 32'hCAFE_0042, 32'h0, 5'd17, 32'h0000_1010, 0, 32'h5555_5555, 1'b1);
        // Store and load encoding together: store wins; unaligned word store and load get aligned.
        do_op(1'b0, 2'b01, 1'b1, 1'b0, 32'h0000_0307, 32'h8765_4321, 5'd0, 32'h0000_1014, 1, 32'h0, 1'b0);
        do_op(1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_010A, 32'h0, 5'd3, 32'h0000_1018, 1, 32'h0BAD_F00D, 1'b0);

        for (int i = 0; i < 10; i++) begin
            int          kind;
            logic [31:0] a;
            logic [31:0] d;
            kind = $urandom_range(0, 3);
            a    = $urandom;
            d    = $urandom;
            case (kind)
                0: do_op(1'b1, 2'b01, 1'b0, 1'b0, a, 32'h0, 5'($urandom), d, $urandom_range(0, 3), $urandom, 1'b0);
                1: do_op(1'b1, 2'b01, 1'b0, 1'b1, a, 32'h0, 5'($urandom), d, $urandom_range(0, 3), $urandom, 1'b0);
                2: do_op(1'b0, 2'b00, 1'b1, 1'($urandom), a, $urandom, 5'd0, d, $urandom_range(0, 3), 32'h0, 1'b0);
                default: do_op(1'b1, 2'($urandom_range(0, 2) * 2), 1'b0, 1'b0, a, 32'h0, 5'($urandom), d, 0, $urandom, 1'($urandom));
            endcase
        end

        // Reset while a load is waiting.
        RegWriteM  = 1'b1;
        ResultSrcM = 2'b01;
        ALUResultM = 32'h0000_0500;
        RdM        = 5'd4;
        PCPlus4M   = 32'h0000_2000;
        mem_ack    = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_val("pre_reset_StallM", {31'b0, StallM}, 32'd1);
            @(posedge clk);
            #2;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_w_zero("midwait_reset");
        @(posedge clk);
        #2;
        rst = 1'b0;
        do_op(1'b1, 2'b01, 1'b0, 1'b0, 32'h0000_0600, 32'h0, 5'd6, 32'h0000_2004, 1, 32'h1357_9BDF, 1'b0);

`ifdef MEM_TIMEOUT_EN
        begin
            w_exp_t e;
            e = '{rw: 1'b1, rs: 2'b01, alu: 32'h0000_0400, rdata: 32'hDEAD_BEEF, chk_rdata: 1'b1,
                  rd: 5'd7, pc4: 32'h0000_3000};
            exp_q.push_back(e);
            for (int c = 0; c <= 4; c++) begin
                RegWriteM  = 1'b1;
                ResultSrcM = 2'b01;
                ALUResultM = 32'h0000_0400;
                RdM        = 5'd7;
                PCPlus4M   = 32'h0000_3000;
                mem_ack    = 1'b0;
                expect_w   = (c == 4);
                @(negedge clk);
                check_val("timeout_StallM", {31'b0, StallM}, {31'b0, (c < 4)});
                @(posedge clk);
                #2;
            end
            expect_w = 1'b0;
            drive_nop();
            repeat (3) begin
                @(negedge clk);
                check_val("timeout_mem_err", {31'b0, mem_err}, 32'd1);
            end
            rst = 1'b1;
            #1;
            check_val("timeout_err_cleared", {31'b0, mem_err}, 32'd0);
            @(posedge clk);
            #2;
            rst = 1'b0;
        end
`endif

        repeat (2) @(posedge clk);
        #2;
        check_val("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
